// File: rtl/apb_regfile.sv
// APB3 completer register bank: ID, CTRL (wait states), STATUS (transfer counters), SCRATCH.
// Optional error responses are enabled by defining APB_REGFILE_SLVERR_EN.
module apb_regfile #(
   parameter int unsigned NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic        pready_o,
   output logic [31:0] prdata_o,
   output logic        pslverr_o
);

   localparam int unsigned   AW         = $clog2(NUM_REGS);
   localparam logic [31:0]   ADDR_LIMIT = 32'(NUM_REGS * 4);
   localparam logic [AW-1:0] IDX_ID     = '0;
   localparam logic [AW-1:0] IDX_CTRL   = AW'(1);
   localparam logic [AW-1:0] IDX_STATUS = AW'(2);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t        state, state_next;

   logic [AW-1:0] idx_q;
   logic          write_q;
   logic [31:0]   wdata_q;
   logic          err_q;
   logic [3:0]    wait_cnt;
   logic [31:0]   prdata_q;

   logic [3:0]    ctrl_wait;
   logic [15:0]   wr_count;
   logic [15:0]   rd_count;
   logic [31:0]   scratch [NUM_REGS];

   logic [AW-1:0] idx;
   logic          addr_bad;
   logic          acc_err;
   logic          setup;
   logic          done;
   logic [31:0]   rd_val;

   assign idx      = paddr_i[2 +: AW];
   assign addr_bad = (paddr_i[1:0] != 2'b00) || (paddr_i >= ADDR_LIMIT);
   assign acc_err  = addr_bad || (pwrite_i && ((idx == IDX_ID) || (idx == IDX_STATUS)));
   assign setup    = (state == IDLE) && psel_i && !penable_i;
   assign done     = psel_i && penable_i && pready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      pready_o   = 1'b0;
      case (state)
         IDLE: begin
            if (setup) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            pready_o = (wait_cnt == 4'd0);
            if (!psel_i) begin
               state_next = IDLE;
            end else if (psel_i && penable_i && (wait_cnt == 4'd0)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read value sampled at setup; STATUS therefore excludes the read's own increment.
   always_comb begin
      rd_val = '0;
      if (!addr_bad) begin
         case (idx)
            IDX_ID:     rd_val = ID_VALUE;
            IDX_CTRL:   rd_val = {28'd0, ctrl_wait};
            IDX_STATUS: rd_val = {rd_count, wr_count};
            default:    rd_val = scratch[idx];
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
         prdata_q <= '0;
      end else if (setup) begin
         idx_q    <= idx;
         write_q  <= pwrite_i;
         wdata_q  <= pwdata_i;
         err_q    <= acc_err;
         wait_cnt <= ctrl_wait;
         prdata_q <= pwrite_i ? 32'd0 : rd_val;
      end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_wait <= '0;
         wr_count  <= '0;
         rd_count  <= '0;
      end else if (done && !err_q) begin
         if (write_q) begin
            if (idx_q == IDX_CTRL) begin
               ctrl_wait <= wdata_q[3:0];
            end
            if (wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
         end else if (rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end

   // NOTE: the register array is small and software-visible, so it is reset like ordinary flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            scratch[i] <= '0;
         end
      end else if (done && !err_q && write_q && (idx_q != IDX_CTRL)) begin
         scratch[idx_q] <= wdata_q;
      end
   end

   assign prdata_o = prdata_q;

`ifdef APB_REGFILE_SLVERR_EN
   assign pslverr_o = pready_o && err_q;
`else
   assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench for apb_regfile: vector table, scoreboard queue, and hand-written corner sequences.
module tb_apb_regfile;

`ifdef APB_REGFILE_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif
   localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;

   logic        clk;
   logic        rst_n;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   apb_regfile #(
      .NUM_REGS(16),
      .ID_VALUE(ID_VALUE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .psel_i   (psel),
      .penable_i(penable),
      .paddr_i  (paddr),
      .pwrite_i (pwrite),
      .pwdata_i (pwdata),
      .pready_o (pready),
      .prdata_o (prdata),
      .pslverr_o(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      int          waits;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_waits;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Reference model of the register file.
   logic [31:0] m_regs [16];
   logic [3:0]  m_ctrl;
   logic [15:0] m_wr;
   logic [15:0] m_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ctrl = '0;
      m_wr   = '0;
      m_rd   = '0;
   endtask

   function automatic logic m_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'd64);
   endfunction

   function automatic logic m_err(input logic wr, input logic [31:0] a);
      logic [3:0] i;
      i = a[5:2];
      return m_bad(a) || (wr && ((i == 4'd0) || (i == 4'd2)));
   endfunction

   function automatic exp_t model_expect(input logic wr, input logic [31:0] a);
      exp_t       e;
      logic [3:0] i;
      i        = a[5:2];
      e.rdata  = '0;
      e.slverr = SLVERR_EN && m_err(wr, a);
      e.waits  = int'(m_ctrl);
      if (!wr && !m_bad(a)) begin
         case (i)
            4'd0:    e.rdata = ID_VALUE;
            4'd1:    e.rdata = {28'd0, m_ctrl};
            4'd2:    e.rdata = {m_rd, m_wr};
            default: e.rdata = m_regs[i];
         endcase
      end
      return e;
   endfunction

   task automatic model_commit(input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic [3:0] i;
      i = a[5:2];
      if (!m_err(wr, a)) begin
         if (wr) begin
            if (i == 4'd1) m_ctrl = d[3:0];
            else           m_regs[i] = d;
            if (m_wr != 16'hFFFF) m_wr++;
         end else if (m_rd != 16'hFFFF) begin
            m_rd++;
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the completion edge.
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input exp_t exp, input string name, output logic [31:0] rd);
      int   waits;
      bit   seen;
      exp_t e;
      sb.push_back(exp);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = data;
      @(posedge clk);
      #1;
      penable = 1'b1;
      paddr   = ~addr;
      pwdata  = ~data;
      waits   = 0;
      seen    = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (pready) begin
            seen = 1'b1;
            break;
         end
         waits++;
      end
      e = sb.pop_front();
      rd = prdata;
      if (!seen) begin
         check({name, " pready timeout"}, 32'd0, 32'd1);
         @(posedge clk);
         #1;
         psel    = 1'b0;
         penable = 1'b0;
      end else begin
         check({name, " prdata"}, prdata, e.rdata);
         check({name, " pslverr"}, 32'(pslverr), 32'(e.slverr));
         check({name, " wait states"}, 32'(waits), 32'(e.waits));
         @(posedge clk);
         #1;
         psel    = 1'b0;
         penable = 1'b0;
         model_commit(wr, addr, data);
      end
   endtask

   task automatic xfer_model(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input string name, output logic [31:0] rd);
      apb_xfer(wr, addr, data, model_expect(wr, addr), name, rd);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      paddr   = '0;
      pwrite  = 1'b0;
      pwdata  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset pready", 32'(pready), 32'd0);
      check("reset prdata", prdata, 32'd0);
      check("reset pslverr", 32'(pslverr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[20];
      exp_t        e;
      logic [31:0] rd;
      logic [31:0] wr_data;

      vecs[0]  = '{1'b0, 32'h00, 32'h0,          32'hA9B0_0001, 1'b0, 0};
      vecs[1]  = '{1'b0, 32'h08, 32'h0,          32'h0001_0000, 1'b0, 0};
      vecs[2]  = '{1'b1, 32'h04, 32'h3,          32'h0,         1'b0, 0};
      vecs[3]  = '{1'b1, 32'h0C, 32'hDEAD_BEEF,  32'h0,         1'b0, 3};
      vecs[4]  = '{1'b0, 32'h0C, 32'h0,          32'hDEAD_BEEF, 1'b0, 3};
      vecs[5]  = '{1'b0, 32'h04, 32'h0,          32'h0000_0003, 1'b0, 3};
      vecs[6]  = '{1'b0, 32'h08, 32'h0,          32'h0004_0002, 1'b0, 3};
      vecs[7]  = '{1'b1, 32'h40, 32'h1111_1111,  32'h0,         1'b1, 3};
      vecs[8]  = '{1'b1, 32'h08, 32'h2222_2222,  32'h0,         1'b1, 3};
      vecs[9]  = '{1'b0, 32'h41, 32'h0,          32'h0,         1'b1, 3};
      vecs[10] = '{1'b1, 32'h02, 32'h5555_5555,  32'h0,         1'b1, 3};
      vecs[11] = '{1'b1, 32'h00, 32'hFFFF_FFFF,  32'h0,         1'b1, 3};
      vecs[12] = '{1'b0, 32'h08, 32'h0,          32'h0005_0002, 1'b0, 3};
      vecs[13] = '{1'b1, 32'h04, 32'hFFFF_FFF2,  32'h0,         1'b0, 3};
      vecs[14] = '{1'b0, 32'h04, 32'h0,          32'h0000_0002, 1'b0, 2};
      vecs[15] = '{1'b1, 32'h04, 32'h0,          32'h0,         1'b0, 2};
      vecs[16] = '{1'b0, 32'h04, 32'h0,          32'h0,         1'b0, 0};
      vecs[17] = '{1'b1, 32'h3C, 32'h1234_5678,  32'h0,         1'b0, 0};
      vecs[18] = '{1'b0, 32'h3C, 32'h0,          32'h1234_5678, 1'b0, 0};
      vecs[19] = '{1'b0, 32'h10, 32'h0,          32'h0,         1'b0, 0};

      do_reset();

      // Back-to-back table transfers.
      for (int i = 0; i < 20; i++) begin
         e.rdata  = vecs[i].exp_rdata;
         e.slverr = vecs[i].exp_err && SLVERR_EN;
         e.waits  = vecs[i].exp_waits;
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, e, $sformatf("vec%0d", i), rd);
      end

      // Alternating writes/reads with random master-side gaps.
      do_reset();
      xfer_model(1'b1, 32'h04, 32'h1, "rnd ctrl", rd);
      wr_data = '0;
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         if (i % 2 == 0) begin
            wr_data = $urandom();
            xfer_model(1'b1, 32'h10, wr_data, $sformatf("rnd%0d wr", i), rd);
         end else begin
            xfer_model(1'b0, 32'h10, 32'h0, $sformatf("rnd%0d rd", i), rd);
            check($sformatf("rnd%0d last write", i), rd, wr_data);
         end
      end
      xfer_model(1'b0, 32'h08, 32'h0, "rnd status", rd);
      check("rnd status value", rd, 32'h0005_0006);

      // Abort: psel dropped after one access cycle with WAIT=5.
      xfer_model(1'b1, 32'h04, 32'h5, "abort ctrl", rd);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h14;
      pwrite  = 1'b1;
      pwdata  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(negedge clk);
      check("abort pready in wait", 32'(pready), 32'd0);
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      check("abort pready after drop", 32'(pready), 32'd0);
      @(posedge clk);
      #1;
      xfer_model(1'b0, 32'h14, 32'h0, "abort readback", rd);
      check("abort scratch unchanged", rd, 32'h0);
      xfer_model(1'b0, 32'h08, 32'h0, "abort status", rd);

      // Enable without a preceding setup is ignored; pready also low right after completion.
      psel    = 1'b1;
      penable = 1'b1;
      paddr   = 32'h10;
      pwrite  = 1'b1;
      pwdata  = 32'hFFFF_0000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("no-setup pready c%0d", c), 32'(pready), 32'd0);
      end
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk);
      #1;
      xfer_model(1'b0, 32'h10, 32'h0, "no-setup readback", rd);
      check("no-setup scratch", rd, wr_data);

      // Reset asserted in an access wait state.
      xfer_model(1'b1, 32'h10, 32'h5A5A_1234, "rst prep", rd);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h10;
      pwrite  = 1'b0;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(negedge clk);
      check("rst prdata before", prdata, 32'h5A5A_1234);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async pready", 32'(pready), 32'd0);
      check("rst async prdata", prdata, 32'd0);
      check("rst async pslverr", 32'(pslverr), 32'd0);
      psel    = 1'b0;
      penable = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer_model(1'b0, 32'h00, 32'h0, "post-rst id", rd);
      xfer_model(1'b0, 32'h10, 32'h0, "post-rst scratch", rd);
      check("post-rst scratch value", rd, 32'h0);
      xfer_model(1'b0, 32'h08, 32'h0, "post-rst status", rd);
      check("post-rst status value", rd, 32'h0002_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
